// File: rtl/branch_unit.sv
// branch_unit: branch resolution stage between fetch and decode.
// Forwards non-branch instructions to decode one cycle after fetch presents
// them, resolves JMP/BZ/BN, and redirects fetch through branch_o/branchloc_o.
// Since fetch cannot stall, wrong-path and flag-pending cycles are handled by
// squashing whatever fetch presents and redirecting afterwards.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start_i                fetch start strobe (restarts this stage too)
//   pc_i, instr_i          fetched address and instruction (same cycle)
//   zero_i, neg_i          architectural flags from execute
//   flags_busy_i           flags not yet valid
//   branch_o, branchloc_o  redirect request and target to fetch
//   valid_o, instr_o,      instruction forwarded to decode and its address
//   instr_pc_o
//   busy_o                 waiting on flags for a held conditional branch
module branch_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              zero_i,
  input  logic              neg_i,
  input  logic              flags_busy_i,
  output logic              branch_o,
  output logic [DATA_W-1:0] branchloc_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] instr_pc_o,
  output logic              busy_o
);

  localparam logic [3:0] JMP_OP = 4'hC;
  localparam logic [3:0] BZ_OP  = 4'hD;
  localparam logic [3:0] BN_OP  = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_REDIR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] loc_q, loc_d;     // redirect target (taken target while waiting)
  logic [DATA_W-1:0] fall_q, fall_d;   // fall-through address of a held branch
  logic              is_bn_q, is_bn_d; // held branch tests neg (else zero)
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] ipc_q, ipc_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] target;
  logic              cond_now;
  logic              cond_held;

  assign op        = instr_i[15:12];
  assign offset    = {{(DATA_W-12){instr_i[11]}}, instr_i[11:0]};
  assign target    = pc_i + offset;  // wraps modulo 2^DATA_W
  assign cond_now  = (op == BN_OP) ? neg_i : zero_i;
  assign cond_held = is_bn_q ? neg_i : zero_i;

  always_comb begin
    state_d = state_q;
    loc_d   = loc_q;
    fall_d  = fall_q;
    is_bn_d = is_bn_q;
    valid_d = 1'b0;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    if (start_i) begin
      // Restart discards the current input and any held branch.
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          if (op == JMP_OP) begin
            loc_d   = target;
            state_d = S_REDIR;
          end else if (op == BZ_OP || op == BN_OP) begin
            if (flags_busy_i) begin
              loc_d   = target;
              fall_d  = pc_i + DATA_W'(1);
              is_bn_d = (op == BN_OP);
              state_d = S_WAIT;
            end else if (cond_now) begin
              loc_d   = target;
              state_d = S_REDIR;
            end
            // Not taken: the branch itself is dropped, fetch is already on
            // the fall-through path.
          end else begin
            valid_d = 1'b1;
            instr_d = instr_i;
            ipc_d   = pc_i;
          end
        end
        S_WAIT: begin
          // Fetch keeps running down fall-through; redirect either way so it
          // comes back to the right address.
          if (!flags_busy_i) begin
            if (!cond_held) loc_d = fall_q;
            state_d = S_REDIR;
          end
        end
        S_REDIR: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      loc_q   <= '0;
      fall_q  <= '0;
      is_bn_q <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      loc_q   <= loc_d;
      fall_q  <= fall_d;
      is_bn_q <= is_bn_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Decoded straight from the state flop so reset drops them asynchronously.
  assign branch_o    = (state_q == S_REDIR);
  assign busy_o      = (state_q == S_WAIT);
  assign branchloc_o = loc_q;
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign instr_pc_o  = ipc_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] pc_i;
  logic [15:0] instr_i;
  logic        zero_i;
  logic        neg_i;
  logic        flags_busy_i;
  logic        branch_o;
  logic [15:0] branchloc_o;
  logic        valid_o;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rom [0:65535];
  logic [15:0] fpc;
  logic [15:0] start_addr;
  logic [31:0] exp_q [$];

  branch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .instr_i      (instr_i),
    .zero_i       (zero_i),
    .neg_i        (neg_i),
    .flags_busy_i (flags_busy_i),
    .branch_o     (branch_o),
    .branchloc_o  (branchloc_o),
    .valid_o      (valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal fetch unit: start loads the start address, a redirect loads the
  // target, otherwise pc increments.
  always @(posedge clk) begin
    if (start_i)       fpc <= start_addr;
    else if (branch_o) fpc <= branchloc_o;
    else               fpc <= fpc + 16'd1;
  end
  assign pc_i    = fpc;
  assign instr_i = rom[fpc];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called mid-cycle once inputs are set; fwd marks the presented
  // instruction as one decode must receive.
  task automatic step(input bit fwd);
    if (fwd) exp_q.push_back({fpc, rom[fpc]});
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] addr);
    start_addr = addr;
    start_i    = 1'b1;
    step(0);
    start_i    = 1'b0;
  endtask

  // Scoreboard: every forwarded instruction must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", {instr_pc_o, instr_o}, 32'h0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("fwd_pc", {16'h0, instr_pc_o}, {16'h0, e[31:16]});
        check_eq("fwd_instr", {16'h0, instr_o}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = {4'h1, a[11:0]};
    rom[16'h0010] = 16'hC005;
    rom[16'h0001] = 16'hCFFE;
    rom[16'hFFFE] = 16'hC005;
    rom[16'h0020] = 16'hD004;
    rom[16'h0030] = 16'hE010;
    fpc = 16'h0100;
    rst_n = 1'b0; start_i = 1'b0; start_addr = 16'h0;
    zero_i = 1'b0; neg_i = 1'b0; flags_busy_i = 1'b0;

    // Reset values
    #2;
    check_eq("rst_branch", {31'h0, branch_o}, 32'h0);
    check_eq("rst_loc", {16'h0, branchloc_o}, 32'h0);
    check_eq("rst_valid", {31'h0, valid_o}, 32'h0);
    check_eq("rst_instr", {16'h0, instr_o}, 32'h0);
    check_eq("rst_ipc", {16'h0, instr_pc_o}, 32'h0);
    check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE squashes everything, even a JMP at pc 0x0010
    fpc = 16'h000F;
    for (int i = 0; i < 3; i++) begin
      check_eq("idle_branch", {31'h0, branch_o}, 32'h0);
      check_eq("idle_busy", {31'h0, busy_o}, 32'h0);
      step(0);
    end

    // Start at 0x0010 with a plain instruction there
    rom[16'h0010] = 16'h1010;
    do_start(16'h0010);
    step(1); step(1); step(1);

    // JMP 0xC005 at 0x0010 -> 0x0015
    rom[16'h0010] = 16'hC005;
    do_start(16'h0010);
    step(0);
    check_eq("jmp_branch", {31'h0, branch_o}, 32'h1);
    check_eq("jmp_loc", {16'h0, branchloc_o}, 32'h0015);
    step(0);
    check_eq("jmp_newpc", {16'h0, fpc}, 32'h0015);
    check_eq("jmp_branch_low", {31'h0, branch_o}, 32'h0);
    step(1); step(1);

    // JMP wrap: 0xCFFE at 0x0001 -> 0xFFFF
    do_start(16'h0001);
    step(0);
    check_eq("wrap_neg_loc", {16'h0, branchloc_o}, 32'hFFFF);
    step(0);
    step(1); step(1);
    // pc now at 0x0001 (a JMP): start wins, then JMP at 0xFFFE -> 0x0003
    do_start(16'hFFFE);
    step(0);
    check_eq("wrap_pos_loc", {16'h0, branchloc_o}, 32'h0003);
    check_eq("wrap_pos_branch", {31'h0, branch_o}, 32'h1);
    step(0);
    step(1);

    // BZ taken with flags ready
    zero_i = 1'b1;
    do_start(16'h0020);
    step(0);
    check_eq("bz_t_branch", {31'h0, branch_o}, 32'h1);
    check_eq("bz_t_loc", {16'h0, branchloc_o}, 32'h0024);
    step(0);
    step(1);

    // BZ not taken: fall-through forwarded without redirect
    zero_i = 1'b0;
    do_start(16'h0020);
    step(0);
    check_eq("bz_nt_branch", {31'h0, branch_o}, 32'h0);
    step(1);
    check_eq("bz_nt_branch2", {31'h0, branch_o}, 32'h0);
    step(1);

    // BN waiting 3 cycles, then not taken / taken
    for (int k = 0; k < 2; k++) begin
      do_start(16'h0030);
      flags_busy_i = 1'b1; neg_i = 1'b0;
      step(0);
      for (int w = 0; w < 3; w++) begin
        check_eq("bn_busy", {31'h0, busy_o}, 32'h1);
        check_eq("bn_wait_branch", {31'h0, branch_o}, 32'h0);
        if (w == 2) begin
          flags_busy_i = 1'b0;
          neg_i = (k == 1);
        end
        step(0);
      end
      check_eq("bn_busy_done", {31'h0, busy_o}, 32'h0);
      check_eq("bn_branch", {31'h0, branch_o}, 32'h1);
      check_eq("bn_loc", {16'h0, branchloc_o}, (k == 1) ? 32'h0040 : 32'h0031);
      neg_i = 1'b0;
      step(0);
      step(1);
    end

    // start_i during WAIT cancels the held branch
    do_start(16'h0030);
    flags_busy_i = 1'b1;
    step(0);
    check_eq("sw_busy", {31'h0, busy_o}, 32'h1);
    start_addr = 16'h0050; start_i = 1'b1;
    step(0);
    start_i = 1'b0; flags_busy_i = 1'b0;
    check_eq("sw_busy_low", {31'h0, busy_o}, 32'h0);
    check_eq("sw_no_branch", {31'h0, branch_o}, 32'h0);
    step(1);
    check_eq("sw_no_branch2", {31'h0, branch_o}, 32'h0);
    step(1);

    // Asynchronous reset during REDIR
    do_start(16'h0010);
    step(0);
    check_eq("rr_branch", {31'h0, branch_o}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rr_branch_drop", {31'h0, branch_o}, 32'h0);
    check_eq("rr_loc", {16'h0, branchloc_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rr_idle_branch", {31'h0, branch_o}, 32'h0);
      check_eq("rr_idle_busy", {31'h0, busy_o}, 32'h0);
      step(0);
    end

    step(0); step(0);
    check_eq("sb_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
